// File: rtl/hierarquia_pkg.sv
// Shared encodings and default widths for the L1 cache sequencer.
package hierarquia_pkg;

  localparam int ADDR_W_D = 5;
  localparam int DATA_W_D = 3;
  localparam int CNT_W_D  = 8;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_LOOKUP  = 2'b01,
    OP_INSTALL = 2'b10,
    OP_WRITE   = 2'b11
  } cache_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_WRITEBACK,
    ST_FILL,
    ST_INSTALL,
    ST_DONE
  } estado_e;

endpackage

// File: rtl/controlador_cache_contador.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module contador_saturado #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/controlador_cache.sv
// One-request-at-a-time sequencer between the CPU port and a 2-way L1:
// lookup, optional dirty write-back, fill or direct install, completion pulse.
module controlador_cache
  import hierarquia_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_hit,
  output logic [1:0]        cache_op,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_dirty_in,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_q,
  input  logic              cache_victim_valid,
  input  logic              cache_victim_dirty,
  input  logic [ADDR_W-1:0] cache_victim_address,
  input  logic [DATA_W-1:0] cache_victim_data,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  estado_e state, state_nx;

  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] fill_q;
  logic              hit_q;
  logic [ADDR_W-1:0] vic_addr_q;
  logic [DATA_W-1:0] vic_data_q;
  logic [DATA_W-1:0] q_r;
  logic              hit_r;

  logic victim_wb;
  assign victim_wb = cache_victim_valid & cache_victim_dirty;

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (cpu_req) state_nx = ST_LOOKUP;
      ST_LOOKUP:    state_nx = ST_CHECK;
      ST_CHECK: begin
        if (cache_hit)      state_nx = ST_DONE;
        else if (victim_wb) state_nx = ST_WRITEBACK;
        else if (wren_q)    state_nx = ST_INSTALL;
        else                state_nx = ST_FILL;
      end
      ST_WRITEBACK: if (mem_ack) state_nx = wren_q ? ST_INSTALL : ST_FILL;
      ST_FILL:      if (mem_ack) state_nx = ST_INSTALL;
      ST_INSTALL:   state_nx = ST_DONE;
      ST_DONE:      state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    cpu_ready      = 1'b0;
    cpu_done       = 1'b0;
    cache_op       = OP_NOP;
    cache_wdata    = '0;
    cache_dirty_in = 1'b0;
    mem_req        = 1'b0;
    mem_wren       = 1'b0;
    mem_address    = '0;
    mem_wdata      = '0;
    case (state)
      ST_IDLE:   cpu_ready = 1'b1;
      ST_LOOKUP: cache_op  = OP_LOOKUP;
      ST_CHECK: if (cache_hit && wren_q) begin
        cache_op    = OP_WRITE;
        cache_wdata = data_q;
      end
      ST_WRITEBACK: begin
        mem_req     = 1'b1;
        mem_wren    = 1'b1;
        mem_address = vic_addr_q;
        mem_wdata   = vic_data_q;
      end
      ST_FILL: begin
        mem_req     = 1'b1;
        mem_address = addr_q;
      end
      ST_INSTALL: begin
        cache_op       = OP_INSTALL;
        cache_wdata    = wren_q ? data_q : fill_q;
        cache_dirty_in = wren_q;
      end
      ST_DONE:   cpu_done = 1'b1;
      default: ;
    endcase
  end

  assign cache_address = addr_q;
  assign cpu_q         = q_r;
  assign cpu_hit       = hit_r;

  // cpu_q/cpu_hit load only on entry to DONE so they hold between completions
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      fill_q     <= '0;
      hit_q      <= 1'b0;
      vic_addr_q <= '0;
      vic_data_q <= '0;
      q_r        <= '0;
      hit_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cpu_req) begin
          wren_q <= cpu_wren;
          addr_q <= cpu_address;
          data_q <= cpu_data;
        end
        ST_CHECK: begin
          hit_q <= cache_hit;
          if (cache_hit) begin
            q_r   <= wren_q ? data_q : cache_q;
            hit_r <= 1'b1;
          end else if (victim_wb) begin
            vic_addr_q <= cache_victim_address;
            vic_data_q <= cache_victim_data;
          end
        end
        ST_FILL: if (mem_ack) fill_q <= mem_rdata;
        ST_INSTALL: begin
          q_r   <= wren_q ? data_q : fill_q;
          hit_r <= hit_q;
        end
        default: ;
      endcase
    end
  end

  contador_saturado #(.CNT_W(CNT_W)) u_hit (
    .clock(clock), .reset_n(reset_n),
    .inc(state == ST_CHECK && cache_hit), .count(hit_count)
  );

  contador_saturado #(.CNT_W(CNT_W)) u_miss (
    .clock(clock), .reset_n(reset_n),
    .inc(state == ST_CHECK && !cache_hit), .count(miss_count)
  );

  contador_saturado #(.CNT_W(CNT_W)) u_wb (
    .clock(clock), .reset_n(reset_n),
    .inc(state == ST_WRITEBACK && mem_ack), .count(wb_count)
  );

endmodule

// File: tb/tb_controlador_cache.sv
// Vector table plus scoreboard for controlador_cache; cache and memory are
// modelled by the bench, completions are checked as cpu_done appears.
module tb_controlador_cache;

  logic       clock, reset_n;
  logic       cpu_req, cpu_wren;
  logic [4:0] cpu_address;
  logic [2:0] cpu_data;
  logic       cpu_ready, cpu_done, cpu_hit;
  logic [2:0] cpu_q;
  logic [1:0] cache_op;
  logic [4:0] cache_address;
  logic [2:0] cache_wdata;
  logic       cache_dirty_in;
  logic       cache_hit;
  logic [2:0] cache_q;
  logic       cache_victim_valid, cache_victim_dirty;
  logic [4:0] cache_victim_address;
  logic [2:0] cache_victim_data;
  logic       mem_req, mem_wren;
  logic [4:0] mem_address;
  logic [2:0] mem_wdata, mem_rdata;
  logic       mem_ack;
  logic [7:0] hit_count, miss_count, wb_count;

  controlador_cache dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_address(cpu_address),
    .cpu_data(cpu_data), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .cpu_q(cpu_q), .cpu_hit(cpu_hit),
    .cache_op(cache_op), .cache_address(cache_address),
    .cache_wdata(cache_wdata), .cache_dirty_in(cache_dirty_in),
    .cache_hit(cache_hit), .cache_q(cache_q),
    .cache_victim_valid(cache_victim_valid), .cache_victim_dirty(cache_victim_dirty),
    .cache_victim_address(cache_victim_address), .cache_victim_data(cache_victim_data),
    .mem_req(mem_req), .mem_wren(mem_wren), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       wren;  logic [4:0] addr;   logic [2:0] data;
    logic       c_hit; logic [2:0] c_q;
    logic       v_valid; logic v_dirty; logic [4:0] v_addr; logic [2:0] v_data;
    int         delay; logic [2:0] rdata;
    logic [2:0] e_q;   logic e_hit; int e_lat;
    int         e_nmem; logic e_m0_wren; logic [4:0] e_m0_addr; logic [2:0] e_m0_data;
    int         e_ninst; logic e_idirty; logic [2:0] e_idata;
    int         e_nwr;
  } vec_t;

  typedef struct { logic [2:0] q; logic hit; int lat; } exp_t;
  typedef struct { logic wren; logic [4:0] addr; logic [2:0] data; } mem_t;

  exp_t       exp_q[$];
  mem_t       mem_log[$];
  int         errors = 0, checks = 0;
  int         cyc = 0, acc_cyc = 0, done_cnt = 0;
  int         inst_cnt = 0, wr_cnt = 0;
  logic       inst_dirty;
  logic [2:0] inst_data, wr_data;
  logic [4:0] cur_addr = '0;
  int         cur_delay = 1;
  logic [2:0] cur_rdata = '0;
  bit         idle_ack = 1'b0;
  int         exp_hits = 0, exp_miss = 0, exp_wb = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memory model: acks after cur_delay cycles of mem_req, logs each transfer
  initial begin
    int mcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (mem_req) begin
        mcnt++;
        if (mcnt == cur_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = cur_rdata;
          mem_log.push_back('{mem_wren, mem_address, mem_wdata});
          mcnt = 0;
        end
      end else begin
        mcnt = 0;
        if (idle_ack) mem_ack = 1'(($urandom % 2));
      end
    end
  end

  // completion monitor and cache-port observer
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (cpu_done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got cpu_done=1 expected none pending");
          end else begin
            e = exp_q.pop_front();
            chk("cpu_q", 32'(cpu_q), 32'(e.q));
            chk("cpu_hit", 32'(cpu_hit), 32'(e.hit));
            chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
          end
        end
        if (cache_op == 2'b01) chk("lookup_addr", 32'(cache_address), 32'(cur_addr));
        if (cache_op == 2'b10) begin
          inst_cnt++; inst_dirty = cache_dirty_in; inst_data = cache_wdata;
        end
        if (cache_op == 2'b11) begin
          wr_cnt++; wr_data = cache_wdata;
        end
      end
      cyc++;
    end
  end

  task automatic do_req(logic wr, logic [4:0] a, logic [2:0] d,
                        logic [2:0] eq, logic eh, int el, bit wait_done);
    int start, t;
    @(negedge clock);
    start = done_cnt;
    cpu_wren = wr; cpu_address = a; cpu_data = d; cpu_req = 1'b1;
    cur_addr = a;
    exp_q.push_back('{eq, eh, el});
    @(posedge clock);
    acc_cyc = cyc;
    #1;
    cpu_req = 1'b0;
    cpu_address = 5'($urandom); cpu_data = 3'($urandom); cpu_wren = 1'($urandom);
    if (wait_done) begin
      t = 0;
      while (done_cnt == start && t < 100) begin
        @(negedge clock);
        t++;
      end
      if (t >= 100) begin
        checks++; errors++;
        $display("FAIL done_timeout: got no cpu_done expected one within 100 cycles");
      end
    end
  endtask

  task automatic set_cache(logic h, logic [2:0] q, logic vv, logic vd,
                           logic [4:0] va, logic [2:0] vdat);
    cache_hit = h; cache_q = q; cache_victim_valid = vv;
    cache_victim_dirty = vd; cache_victim_address = va; cache_victim_data = vdat;
  endtask

  vec_t vt[7];

  initial begin
    int m0, i0, w0, t, d0;
    vec_t v;

    vt[0] = '{0,5'b10000,3'b000, 0,3'b000, 0,0,5'b00000,3'b000, 2,3'b100,
              3'b100,0,6, 1,0,5'b10000,3'b000, 1,0,3'b100, 0};
    vt[1] = '{0,5'b10000,3'b000, 1,3'b100, 0,0,5'b00000,3'b000, 2,3'b000,
              3'b100,1,3, 0,0,5'b00000,3'b000, 0,0,3'b000, 0};
    vt[2] = '{1,5'b00001,3'b101, 1,3'b000, 0,0,5'b00000,3'b000, 2,3'b000,
              3'b101,1,3, 0,0,5'b00000,3'b000, 0,0,3'b000, 1};
    vt[3] = '{1,5'b01001,3'b100, 0,3'b000, 1,1,5'b00001,3'b101, 1,3'b000,
              3'b100,0,5, 1,1,5'b00001,3'b101, 1,1,3'b100, 0};
    vt[4] = '{0,5'b00110,3'b000, 0,3'b000, 1,1,5'b11110,3'b011, 3,3'b010,
              3'b010,0,10, 2,1,5'b11110,3'b011, 1,0,3'b010, 0};
    vt[5] = '{0,5'b01010,3'b000, 0,3'b000, 1,0,5'b00111,3'b110, 1,3'b111,
              3'b111,0,5, 1,0,5'b01010,3'b000, 1,0,3'b111, 0};
    vt[6] = '{1,5'b11111,3'b001, 0,3'b000, 0,0,5'b00000,3'b000, 1,3'b000,
              3'b001,0,4, 0,0,5'b00000,3'b000, 1,1,3'b001, 0};

    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_wren = 1'b0; cpu_address = '0; cpu_data = '0;
    set_cache(0, '0, 0, 0, '0, '0);
    #3;
    chk("rst_ready", 32'(cpu_ready), 1);
    chk("rst_done", 32'(cpu_done), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_cache_op", 32'(cache_op), 0);
    chk("rst_cpu_q", 32'(cpu_q), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      v = vt[i];
      set_cache(v.c_hit, v.c_q, v.v_valid, v.v_dirty, v.v_addr, v.v_data);
      cur_delay = v.delay; cur_rdata = v.rdata;
      m0 = mem_log.size(); i0 = inst_cnt; w0 = wr_cnt;
      do_req(v.wren, v.addr, v.data, v.e_q, v.e_hit, v.e_lat, 1);
      exp_hits += int'(v.c_hit);
      exp_miss += int'(!v.c_hit);
      exp_wb   += int'(!v.c_hit && v.v_valid && v.v_dirty);
      chk($sformatf("v%0d_nmem", i), 32'(mem_log.size() - m0), 32'(v.e_nmem));
      if (v.e_nmem > 0 && mem_log.size() > m0) begin
        chk($sformatf("v%0d_m0_wren", i), 32'(mem_log[m0].wren), 32'(v.e_m0_wren));
        chk($sformatf("v%0d_m0_addr", i), 32'(mem_log[m0].addr), 32'(v.e_m0_addr));
        if (v.e_m0_wren)
          chk($sformatf("v%0d_m0_data", i), 32'(mem_log[m0].data), 32'(v.e_m0_data));
      end
      if (v.e_nmem == 2 && mem_log.size() > m0 + 1) begin
        chk($sformatf("v%0d_m1_wren", i), 32'(mem_log[m0+1].wren), 0);
        chk($sformatf("v%0d_m1_addr", i), 32'(mem_log[m0+1].addr), 32'(v.addr));
      end
      chk($sformatf("v%0d_ninst", i), 32'(inst_cnt - i0), 32'(v.e_ninst));
      if (v.e_ninst > 0) begin
        chk($sformatf("v%0d_idirty", i), 32'(inst_dirty), 32'(v.e_idirty));
        chk($sformatf("v%0d_idata", i), 32'(inst_data), 32'(v.e_idata));
      end
      chk($sformatf("v%0d_nwr", i), 32'(wr_cnt - w0), 32'(v.e_nwr));
      if (v.e_nwr > 0) chk($sformatf("v%0d_wrdata", i), 32'(wr_data), 32'(v.data));
    end
    chk("hit_count", 32'(hit_count), 32'(exp_hits));
    chk("miss_count", 32'(miss_count), 32'(exp_miss));
    chk("wb_count", 32'(wb_count), 32'(exp_wb));

    // reset while FILL waits on a slow memory
    set_cache(0, '0, 0, 0, '0, '0);
    cur_delay = 20;
    do_req(0, 5'b00010, 3'b000, 3'b000, 0, 0, 0);
    t = 0;
    while (!mem_req && t < 20) begin @(negedge clock); t++; end
    chk("fill_mem_req", 32'(mem_req), 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_done", 32'(cpu_done), 0);
    chk("arst_ready", 32'(cpu_ready), 1);
    chk("arst_miss_count", 32'(miss_count), 0);
    chk("arst_wb_count", 32'(wb_count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (5) @(negedge clock);
    chk("arst_no_done", 32'(done_cnt - d0), 0);
    cur_delay = 1;
    set_cache(1, 3'b011, 0, 0, '0, '0);
    do_req(0, 5'b00100, 3'b000, 3'b011, 1, 3, 1);
    chk("post_rst_hits", 32'(hit_count), 1);

    // saturation with stray acks while idle
    exp_hits = 1;
    m0 = mem_log.size();
    idle_ack = 1'b1;
    for (int k = 0; k < 300; k++) begin
      set_cache(1, 3'(k), 0, 0, '0, '0);
      do_req(0, 5'(k), 3'b000, 3'(k), 1, 3, 1);
      if (exp_hits < 255) exp_hits++;
    end
    idle_ack = 1'b0;
    chk("sat_hit_count", 32'(hit_count), 32'(exp_hits));
    chk("sat_miss_count", 32'(miss_count), 0);
    chk("sat_wb_count", 32'(wb_count), 0);
    chk("sat_no_mem", 32'(mem_log.size() - m0), 0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
